scan_sel_gen: RTL and testbench
===============================

SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-count input and internal dwell counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  run enable; 1 = auto-scan, 0 = hold/idle.
REQ-005 dir  input  1  scan direction; 0 = up (0,1,2,3), 1 = down (3,2,1,0).
REQ-006 dwell  input  DWELL_W  cycles per position minus one; dwell=N gives N+1 cycles per position.
REQ-007 step_req  input  1  manual single-step request, rising-edge sensitive, honoured only in IDLE.
REQ-008 A  output  1  position bit 1 (MSB), drives 2-to-4 decoder input A.
REQ-009 B  output  1  position bit 0 (LSB), drives 2-to-4 decoder input B.
REQ-010 tick  output  1  one-cycle pulse in the first cycle A/B show a new position.
REQ-011 wrap  output  1  one-cycle pulse coincident with tick when position wraps (3->0 up, 0->3 down).
REQ-012 busy  output  1  1 while FSM is in RUN.

Function
REQ-013 Internal 2-bit position pos; A = pos[1], B = pos[0]; all outputs registered.
REQ-014 FSM states IDLE, RUN; IDLE -> RUN when en=1 sampled; RUN -> IDLE when en=0 sampled.
REQ-015 On IDLE->RUN: dwell counter cleared to 0, dwell value latched; pos unchanged.
REQ-016 In RUN: counter increments each cycle; when counter == latched dwell, counter -> 0, pos advances one step per dir, dwell re-latched.
REQ-017 First advance occurs dwell+1 cycles after the first RUN cycle; thereafter every dwell+1 cycles.
REQ-018 dwell=0: pos advances every cycle in RUN; tick held high continuously.
REQ-019 Change of dwell mid-position: takes effect from the next position only.
REQ-020 Change of dir mid-position: takes effect at the next advance; pos never skips or repeats.
REQ-021 Wrap arithmetic: pos is modulo-4; wrap asserted only on 3->0 (dir=0) or 0->3 (dir=1).
REQ-022 RUN -> IDLE: pos held at current value; counter cleared; no tick on the exit cycle.
REQ-023 In IDLE: each 0->1 transition of step_req advances pos by one step per dir, with tick (and wrap if applicable) one cycle later.
REQ-024 step_req held high: exactly one advance; further advance needs a fresh 0->1 transition.
REQ-025 step_req edge in the same cycle en is sampled 1: en wins, step ignored, no extra advance.
REQ-026 step_req edges in RUN are ignored and not queued.

Reset
REQ-027 rst=1 at a clock edge: state IDLE, pos=0 (A=0,B=0), counter=0, tick=0, wrap=0, busy=0, step edge-detect history=0.
REQ-028 rst mid-RUN: same values on next edge; en still high after rst release re-enters RUN per REQ-015.
REQ-029 rst has priority over en, step_req and all counter events.

Structure
REQ-030 Shared package/header holds state encodings (IDLE, RUN) and DWELL_W default.
REQ-031 One sub-module: step_edge_det (registered rising-edge detector for step_req, synchronous reset).

Verification
REQ-032 rst, en=1, dir=0, dwell=1 -> A,B = 00,01,10,11,00 each held 2 cycles; wrap on 11->00 only; busy=1.
REQ-033 en=1, dir=1, dwell=0 -> pos 0,3,2,1,0 one per cycle; tick constant 1; wrap on 0->3.
REQ-034 en=0, pos=2, step_req pulsed 3 times (held 4 cycles each) -> pos 3,0,1; wrap once; tick 3 single pulses.
REQ-035 dwell=3 in RUN, change to 0 mid-position -> current position lasts 4 cycles, following positions 1 cycle.
REQ-036 rst asserted mid-RUN at pos=3 -> next edge A=B=0, tick=wrap=busy=0; en high after release -> first advance after dwell+1 cycles.
REQ-037 en rises with step_req 0->1 same cycle -> no immediate advance; first advance after dwell+1 cycles.

Source files
------------

// File: rtl/scan_sel_gen_pkg.sv
// Shared definitions for the 2-to-4 decoder scan selector: FSM states,
// default dwell width and the position-stepping helpers.
package scan_sel_gen_pkg;

   localparam int DWELL_W_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic [1:0] next_pos(input logic [1:0] pos, input logic dir);
      return dir ? pos - 2'd1 : pos + 2'd1;
   endfunction

   function automatic logic is_wrap(input logic [1:0] pos, input logic dir);
      return dir ? (pos == 2'd0) : (pos == 2'd3);
   endfunction

endpackage

// File: rtl/scan_sel_gen_step_edge_det.sv
// Rising-edge detector for the manual step request; the previous sample is
// registered so an edge is flagged in the cycle step_req is first seen high.
module step_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic step_req,
   output logic step_edge
);

   logic step_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         step_prev <= 1'b0;
      end else begin
         step_prev <= step_req;
      end
   end

   assign step_edge = step_req & ~step_prev;

endmodule

// File: rtl/scan_sel_gen.sv
// Scan selector: walks a 2-bit position (decoder inputs A/B) either
// automatically with a programmable dwell or by manual single steps.
module scan_sel_gen
   import scan_sel_gen_pkg::*;
#(
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               dir,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               step_req,
   output logic               A,
   output logic               B,
   output logic               tick,
   output logic               wrap,
   output logic               busy
);

   localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

   state_t             state;
   logic [1:0]         pos;
   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] dwell_lat;
   logic               step_edge;

   step_edge_det u_step_edge_det (
      .clk       (clk),
      .rst       (rst),
      .step_req  (step_req),
      .step_edge (step_edge)
   );

   assign A = pos[1];
   assign B = pos[0];

   // The dwell value is re-latched at every advance so a new dwell only
   // governs the position that starts after the current one ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pos       <= 2'd0;
         cnt       <= '0;
         dwell_lat <= '0;
         tick      <= 1'b0;
         wrap      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  dwell_lat <= dwell;
               end else if (step_edge) begin
                  pos  <= next_pos(pos, dir);
                  tick <= 1'b1;
                  wrap <= is_wrap(pos, dir);
               end
            end
            RUN: begin
               if (!en) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (cnt == dwell_lat) begin
                  cnt       <= '0;
                  dwell_lat <= dwell;
                  pos       <= next_pos(pos, dir);
                  tick      <= 1'b1;
                  wrap      <= is_wrap(pos, dir);
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen: a behavioural model pushes expected
// {A,B,tick,wrap,busy} per cycle into a queue that is popped after each edge.
module tb_scan_sel_gen;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          dir = 1'b0;
   logic [DW-1:0] dwell = '0;
   logic          step_req = 1'b0;
   logic          pos_a, pos_b, tick, wrap, busy;

   int errors = 0;
   int checks = 0;

   logic [4:0] exp_q[$];

   // Model state: remaining cycles before the next advance counts down.
   logic          m_run = 1'b0;
   logic [1:0]    m_pos = 2'd0;
   logic [DW-1:0] m_left = '0;
   logic          m_prev = 1'b0;
   logic          m_tick = 1'b0;
   logic          m_wrap = 1'b0;

   scan_sel_gen #(.DWELL_W(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dir      (dir),
      .dwell    (dwell),
      .step_req (step_req),
      .A        (pos_a),
      .B        (pos_b),
      .tick     (tick),
      .wrap     (wrap),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [4:0] got, input logic [4:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got {A,B,tick,wrap,busy}=%b expected %b at %0t", tag, got, want, $time);
      end
   endtask

   task automatic modelStep(input logic d);
      m_tick = 1'b1;
      if (d) begin
         m_wrap = (m_pos == 2'd0);
         m_pos  = m_pos - 2'd1;
      end else begin
         m_wrap = (m_pos == 2'd3);
         m_pos  = m_pos + 2'd1;
      end
   endtask

   task automatic applyStimulus(input string tag, input logic r, input logic e, input logic d,
                                input logic [DW-1:0] dw, input logic s);
      logic edge_seen;
      rst = r; en = e; dir = d; dwell = dw; step_req = s;
      if (r) begin
         m_run = 1'b0; m_pos = 2'd0; m_left = '0; m_prev = 1'b0;
         m_tick = 1'b0; m_wrap = 1'b0;
      end else begin
         edge_seen = s && !m_prev;
         m_prev = s;
         m_tick = 1'b0;
         m_wrap = 1'b0;
         if (!m_run) begin
            if (e) begin
               m_run  = 1'b1;
               m_left = dw;
            end else if (edge_seen) begin
               modelStep(d);
            end
         end else begin
            if (!e) begin
               m_run = 1'b0;
            end else if (m_left == '0) begin
               modelStep(d);
               m_left = dw;
            end else begin
               m_left = m_left - 1'b1;
            end
         end
      end
      exp_q.push_back({m_pos[1], m_pos[0], m_tick, m_wrap, m_run});
      @(posedge clk);
      #1;
      checkOutput(tag, {pos_a, pos_b, tick, wrap, busy}, exp_q.pop_front());
   endtask

   initial begin
      // Reset state
      repeat (2) applyStimulus("reset", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

      // Up scan, two cycles per position, through a wrap
      repeat (12) applyStimulus("up_dwell1", 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
      applyStimulus("run_exit", 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
      applyStimulus("idle_hold", 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);

      // Down scan, one cycle per position
      applyStimulus("reset2", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      repeat (7) applyStimulus("down_dwell0", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
      applyStimulus("run_exit2", 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);

      // Manual stepping: two steps up to pos 2, then three held pulses
      applyStimulus("reset3", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      for (int p = 0; p < 5; p++) begin
         repeat (4) applyStimulus("step_hi", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
         repeat (2) applyStimulus("step_lo", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      end

      // Dwell shortened mid-position
      applyStimulus("reset4", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      repeat (2) applyStimulus("dwell3", 1'b0, 1'b1, 1'b0, 8'd3, 1'b0);
      repeat (8) applyStimulus("dwell0_late", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

      // Reset mid-run at pos 3, then re-entry with en still high
      applyStimulus("reset5", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      repeat (8) applyStimulus("run_to3", 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
      applyStimulus("rst_midrun", 1'b1, 1'b1, 1'b0, 8'd2, 1'b0);
      repeat (6) applyStimulus("rerun", 1'b0, 1'b1, 1'b0, 8'd2, 1'b0);

      // en and step rising together: step is ignored
      applyStimulus("reset6", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      applyStimulus("pre_idle", 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
      repeat (5) applyStimulus("en_step", 1'b0, 1'b1, 1'b0, 8'd2, 1'b1);
      applyStimulus("exit_step_hi", 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);
      applyStimulus("idle_step_hi", 1'b0, 1'b0, 1'b0, 8'd2, 1'b1);

      // Mixed random traffic
      for (int i = 0; i < 300; i++) begin
         applyStimulus("random", ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
